// File: rtl/msx_slot_bridge.sv
// MSX cartridge-slot to multiplexed host-bus bridge: holds the Z80 with WAIT, runs an
// address/data handshake, bounded by a host timeout. Define IORQ_BRIDGE_EN to also bridge I/O cycles.
module msx_slot_bridge #(
  parameter int          HOST_W      = 16,
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [7:0]  IO_BASE     = 8'h98,
  parameter logic [7:0]  IO_MASK     = 8'hFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] maddr,
  input  logic [DATA_W-1:0] mdata_in,
  output logic [DATA_W-1:0] mdata_out,
  output logic              mdata_oe,
  input  logic              msltsl,
  input  logic              mmreq,
  input  logic              miorq,
  input  logic              mrd,
  input  logic              mwr,
  input  logic              mm1,
  output logic              mwait_oe,
  output logic              mreset,
  output logic              cs,
  output logic              rw,
  output logic              rmirq,
  input  logic              a0,
  input  logic [HOST_W-1:0] md_in,
  output logic [HOST_W-1:0] md_out,
  output logic              md_oe,
  input  logic              rdone,
  input  logic              rreset,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RELEASE} state_t;

  // Read word returned to the MSX: host data, or all-ones when the host never answered.
  function automatic logic [DATA_W-1:0] rd_word(input logic tmo, input logic [HOST_W-1:0] md);
    return tmo ? {DATA_W{1'b1}} : md[DATA_W-1:0];
  endfunction

  function automatic logic [HOST_W-1:0] addr_word(input logic [ADDR_W-1:0] a, input logic io);
    return io ? HOST_W'(a[7:0]) : HOST_W'(a);
  endfunction

  // ---- p0..pN: MSX input synchronisers (strobes idle high after reset) ----
  logic [5:0]        strb_p [SYNC_STAGES];
  logic [ADDR_W-1:0] addr_p [SYNC_STAGES];
  logic [DATA_W-1:0] wdat_p [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) strb_p[i] <= '1;
    end else begin
      strb_p[0] <= {msltsl, mmreq, miorq, mrd, mwr, mm1};
      for (int i = 1; i < SYNC_STAGES; i++) strb_p[i] <= strb_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_p[0] <= maddr;
    wdat_p[0] <= mdata_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      addr_p[i] <= addr_p[i-1];
      wdat_p[i] <= wdat_p[i-1];
    end
  end

  logic              s_sltsl, s_mreq, s_iorq, s_rd, s_wr, s_m1;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdat;

  assign {s_sltsl, s_mreq, s_iorq, s_rd, s_wr, s_m1} = strb_p[SYNC_STAGES-1];
  assign s_addr = addr_p[SYNC_STAGES-1];
  assign s_wdat = wdat_p[SYNC_STAGES-1];

  // ---- cycle detection on synchronised strobes ----
  logic strobe_act, mem_start, io_start, start_ok;
  logic unused_bits;

  assign strobe_act = !s_rd || !s_wr;
  assign mem_start  = !s_sltsl && !s_mreq && strobe_act;
`ifdef IORQ_BRIDGE_EN
  assign io_start   = !s_iorq && s_m1 && strobe_act && ((s_addr[7:0] & IO_MASK) == IO_BASE);
`else
  assign io_start   = 1'b0;
`endif
  assign start_ok    = (mem_start || io_start) && !rdone;
  assign unused_bits = ^{md_in, s_m1, IO_BASE, IO_MASK};

  state_t            state;
  logic              is_io;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] wdat_q;
  logic              tmo_hit, cyc_live, finish, tmo_fire;

  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign cyc_live = is_io ? (!s_iorq && strobe_act) : (!s_sltsl && !s_mreq && strobe_act);

  // rdone beats a simultaneous timeout; in ADDR only the timeout can end the cycle.
  always_comb begin
    finish   = 1'b0;
    tmo_fire = 1'b0;
    if (state == DATA) begin
      finish   = rdone || tmo_hit;
      tmo_fire = tmo_hit && !rdone;
    end else if (state == ADDR) begin
      finish   = tmo_hit;
      tmo_fire = tmo_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start_ok && s_rd) wdat_q <= s_wdat;
  end

  // ---- handshake FSM, all outputs registered ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cs          <= 1'b1;
      rw          <= 1'b1;
      rmirq       <= 1'b1;
      mdata_oe    <= 1'b0;
      mdata_out   <= '0;
      mwait_oe    <= 1'b0;
      md_oe       <= 1'b0;
      md_out      <= '0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
      is_io       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (start_ok) begin
            state    <= ADDR;
            cs       <= 1'b0;
            mwait_oe <= 1'b1;
            rw       <= !s_rd;
            rmirq    <= mem_start;
            is_io    <= !mem_start;
            md_oe    <= 1'b1;
            md_out   <= addr_word(s_addr, !mem_start);
          end
        end
        ADDR, DATA: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (!cyc_live) begin
            state    <= IDLE;
            cs       <= 1'b1;
            mwait_oe <= 1'b0;
            md_oe    <= 1'b0;
          end else if (finish) begin
            state    <= RELEASE;
            cs       <= 1'b1;
            mwait_oe <= 1'b0;
            mdata_oe <= rw;
            if (rw) mdata_out <= rd_word(tmo_fire, md_in);
            if (tmo_fire) timeout_err <= 1'b1;
          end else if (state == ADDR && a0) begin
            state  <= DATA;
            md_oe  <= !rw;
            md_out <= rw ? '0 : HOST_W'(wdat_q);
          end
        end
        RELEASE: begin
          if (s_rd && s_wr) begin
            state    <= IDLE;
            mdata_oe <= 1'b0;
            md_oe    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host-requested MSX reset follows rreset regardless of the bridge reset.
  always_ff @(posedge clk) begin
    mreset <= rreset;
  end

endmodule

// File: tb/tb_msx_slot_bridge.sv
// Directed self-checking bench for msx_slot_bridge (TIMEOUT_CYC overridden to 16).
module tb_msx_slot_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] maddr;
  logic [7:0]  mdata_in, mdata_out;
  logic        mdata_oe, msltsl, mmreq, miorq, mrd, mwr, mm1;
  logic        mwait_oe, mreset, cs, rw, rmirq, a0;
  logic [15:0] md_in, md_out;
  logic        md_oe, rdone, rreset, timeout_err;

  int tests = 0;
  int fails = 0;

  msx_slot_bridge #(.HOST_W(16), .ADDR_W(16), .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .maddr(maddr), .mdata_in(mdata_in), .mdata_out(mdata_out),
    .mdata_oe(mdata_oe), .msltsl(msltsl), .mmreq(mmreq), .miorq(miorq), .mrd(mrd), .mwr(mwr),
    .mm1(mm1), .mwait_oe(mwait_oe), .mreset(mreset), .cs(cs), .rw(rw), .rmirq(rmirq), .a0(a0),
    .md_in(md_in), .md_out(md_out), .md_oe(md_oe), .rdone(rdone), .rreset(rreset),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic msx_idle();
    msltsl = 1'b1; mmreq = 1'b1; miorq = 1'b1; mrd = 1'b1; mwr = 1'b1; mm1 = 1'b1;
    a0 = 1'b0; rdone = 1'b0;
  endtask

  task automatic msx_mem(input logic [15:0] addr, input logic [7:0] data, input logic is_rd);
    maddr = addr; mdata_in = data; msltsl = 1'b0; mmreq = 1'b0;
    mrd = !is_rd; mwr = is_rd;
  endtask

  task automatic test_reset();
    tick(3);
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL rst_cs got=%b exp=1", cs); end
    tests++; if (rw !== 1'b1) begin fails++; $display("FAIL rst_rw got=%b exp=1", rw); end
    tests++; if (rmirq !== 1'b1) begin fails++; $display("FAIL rst_rmirq got=%b exp=1", rmirq); end
    tests++; if (mdata_oe !== 1'b0) begin fails++; $display("FAIL rst_mdata_oe got=%b exp=0", mdata_oe); end
    tests++; if (mdata_out !== 8'h00) begin fails++; $display("FAIL rst_mdata_out got=%h exp=00", mdata_out); end
    tests++; if (mwait_oe !== 1'b0) begin fails++; $display("FAIL rst_mwait got=%b exp=0", mwait_oe); end
    tests++; if (md_oe !== 1'b0) begin fails++; $display("FAIL rst_md_oe got=%b exp=0", md_oe); end
    tests++; if (md_out !== 16'h0000) begin fails++; $display("FAIL rst_md_out got=%h exp=0000", md_out); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_terr got=%b exp=0", timeout_err); end
    rreset = 1'b1; tick();
    tests++; if (mreset !== 1'b1) begin fails++; $display("FAIL rst_mreset_hi got=%b exp=1", mreset); end
    rreset = 1'b0; tick();
    tests++; if (mreset !== 1'b0) begin fails++; $display("FAIL rst_mreset_lo got=%b exp=0", mreset); end
    reset = 1'b0; tick();
  endtask

  task automatic test_write();
    msx_mem(16'h4000, 8'h5A, 1'b0);
    tick(2);
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL wr_cs_early got=%b exp=1", cs); end
    tick();
    tests++; if (cs !== 1'b0) begin fails++; $display("FAIL wr_cs got=%b exp=0", cs); end
    tests++; if (mwait_oe !== 1'b1) begin fails++; $display("FAIL wr_wait got=%b exp=1", mwait_oe); end
    tests++; if (rw !== 1'b0) begin fails++; $display("FAIL wr_rw got=%b exp=0", rw); end
    tests++; if (rmirq !== 1'b1) begin fails++; $display("FAIL wr_rmirq got=%b exp=1", rmirq); end
    tests++; if (md_oe !== 1'b1 || md_out !== 16'h4000) begin fails++; $display("FAIL wr_addr got=%b/%h exp=1/4000", md_oe, md_out); end
    tick(2);
    a0 = 1'b1; tick();
    tests++; if (md_oe !== 1'b1 || md_out !== 16'h005A) begin fails++; $display("FAIL wr_data got=%b/%h exp=1/005a", md_oe, md_out); end
    tick();
    tests++; if (mwait_oe !== 1'b1) begin fails++; $display("FAIL wr_wait_hold got=%b exp=1", mwait_oe); end
    rdone = 1'b1; tick();
    tests++; if (mwait_oe !== 1'b0 || cs !== 1'b1) begin fails++; $display("FAIL wr_done got=%b/%b exp=0/1", mwait_oe, cs); end
    tests++; if (mdata_oe !== 1'b0) begin fails++; $display("FAIL wr_mdata_oe got=%b exp=0", mdata_oe); end
    msx_idle(); tick(2);
    tests++; if (md_oe !== 1'b1) begin fails++; $display("FAIL wr_rel_hold got=%b exp=1", md_oe); end
    tick();
    tests++; if (md_oe !== 1'b0) begin fails++; $display("FAIL wr_rel got=%b exp=0", md_oe); end
    tick();
  endtask

  task automatic test_read();
    msx_mem(16'h8123, 8'h00, 1'b1);
    tick(3);
    tests++; if (cs !== 1'b0 || rw !== 1'b1) begin fails++; $display("FAIL rd_start got=%b/%b exp=0/1", cs, rw); end
    tests++; if (md_out !== 16'h8123) begin fails++; $display("FAIL rd_addr got=%h exp=8123", md_out); end
    a0 = 1'b1; tick();
    tests++; if (md_oe !== 1'b0) begin fails++; $display("FAIL rd_md_oe got=%b exp=0", md_oe); end
    md_in = 16'h00C3; rdone = 1'b1; tick();
    tests++; if (mdata_out !== 8'hC3) begin fails++; $display("FAIL rd_data got=%h exp=c3", mdata_out); end
    tests++; if (mdata_oe !== 1'b1) begin fails++; $display("FAIL rd_oe got=%b exp=1", mdata_oe); end
    tests++; if (mwait_oe !== 1'b0 || cs !== 1'b1) begin fails++; $display("FAIL rd_done got=%b/%b exp=0/1", mwait_oe, cs); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rd_terr got=%b exp=0", timeout_err); end
    rdone = 1'b0; a0 = 1'b0; md_in = 16'h0000; tick();
    tests++; if (mdata_oe !== 1'b1) begin fails++; $display("FAIL rd_oe_hold got=%b exp=1", mdata_oe); end
    msx_idle(); tick(2);
    tests++; if (mdata_oe !== 1'b1) begin fails++; $display("FAIL rd_oe_hold2 got=%b exp=1", mdata_oe); end
    tick();
    tests++; if (mdata_oe !== 1'b0) begin fails++; $display("FAIL rd_oe_rel got=%b exp=0", mdata_oe); end
    tick();
  endtask

  task automatic test_rdone_vs_timeout();
    msx_mem(16'h2222, 8'h00, 1'b1);
    tick(3); tick(2);
    a0 = 1'b1; tick(13);
    tests++; if (mwait_oe !== 1'b1) begin fails++; $display("FAIL race_wait got=%b exp=1", mwait_oe); end
    md_in = 16'h003C; rdone = 1'b1; tick();
    tests++; if (mdata_out !== 8'h3C) begin fails++; $display("FAIL race_data got=%h exp=3c", mdata_out); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL race_terr got=%b exp=0", timeout_err); end
    tests++; if (mwait_oe !== 1'b0) begin fails++; $display("FAIL race_rel got=%b exp=0", mwait_oe); end
    md_in = 16'h0000; msx_idle(); tick(4);
  endtask

  task automatic test_timeout();
    msx_mem(16'h1234, 8'h00, 1'b1);
    tick(3); tick(2);
    a0 = 1'b1; tick(13);
    tests++; if (mwait_oe !== 1'b1 || timeout_err !== 1'b0) begin fails++; $display("FAIL tmo_early got=%b/%b exp=1/0", mwait_oe, timeout_err); end
    tick();
    tests++; if (mwait_oe !== 1'b0 || cs !== 1'b1) begin fails++; $display("FAIL tmo_rel got=%b/%b exp=0/1", mwait_oe, cs); end
    tests++; if (mdata_out !== 8'hFF || mdata_oe !== 1'b1) begin fails++; $display("FAIL tmo_data got=%h/%b exp=ff/1", mdata_out, mdata_oe); end
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL tmo_terr got=%b exp=1", timeout_err); end
    msx_idle(); tick(4);
    msx_mem(16'h4001, 8'hA5, 1'b0);
    tick(3);
    tests++; if (cs !== 1'b0) begin fails++; $display("FAIL tmo_next_cs got=%b exp=0", cs); end
    a0 = 1'b1; tick();
    tests++; if (md_out !== 16'h00A5) begin fails++; $display("FAIL tmo_next_data got=%h exp=00a5", md_out); end
    rdone = 1'b1; tick();
    tests++; if (mwait_oe !== 1'b0 || timeout_err !== 1'b1) begin fails++; $display("FAIL tmo_sticky got=%b/%b exp=0/1", mwait_oe, timeout_err); end
    msx_idle(); tick(4);
  endtask

  task automatic test_reset_mid();
    msx_mem(16'h5000, 8'h11, 1'b0);
    tick(3);
    a0 = 1'b1; tick();
    tests++; if (md_oe !== 1'b1 || cs !== 1'b0) begin fails++; $display("FAIL mid_pre got=%b/%b exp=1/0", md_oe, cs); end
    reset = 1'b1; msx_idle(); tick();
    tests++; if (cs !== 1'b1 || mwait_oe !== 1'b0) begin fails++; $display("FAIL mid_cs_wait got=%b/%b exp=1/0", cs, mwait_oe); end
    tests++; if (md_oe !== 1'b0 || mdata_oe !== 1'b0) begin fails++; $display("FAIL mid_oe got=%b/%b exp=0/0", md_oe, mdata_oe); end
    tests++; if (md_out !== 16'h0000 || timeout_err !== 1'b0) begin fails++; $display("FAIL mid_clr got=%h/%b exp=0000/0", md_out, timeout_err); end
    reset = 1'b0; tick(3);
    msx_mem(16'h6000, 8'h77, 1'b0);
    tick(3);
    tests++; if (cs !== 1'b0 || md_out !== 16'h6000) begin fails++; $display("FAIL mid_next_addr got=%b/%h exp=0/6000", cs, md_out); end
    a0 = 1'b1; tick();
    tests++; if (md_out !== 16'h0077) begin fails++; $display("FAIL mid_next_data got=%h exp=0077", md_out); end
    rdone = 1'b1; tick();
    tests++; if (mwait_oe !== 1'b0 || cs !== 1'b1) begin fails++; $display("FAIL mid_next_done got=%b/%b exp=0/1", mwait_oe, cs); end
    msx_idle(); tick(4);
  endtask

  task automatic test_abort();
    msx_mem(16'h3000, 8'h00, 1'b1);
    mwr = 1'b0;
    tick(3);
    tests++; if (cs !== 1'b0 || rw !== 1'b1) begin fails++; $display("FAIL abort_start got=%b/%b exp=0/1", cs, rw); end
    msx_idle(); tick(2);
    tests++; if (cs !== 1'b0) begin fails++; $display("FAIL abort_hold got=%b exp=0", cs); end
    tick();
    tests++; if (cs !== 1'b1 || mwait_oe !== 1'b0 || md_oe !== 1'b0) begin fails++; $display("FAIL abort got=%b/%b/%b exp=1/0/0", cs, mwait_oe, md_oe); end
    tick(2);
  endtask

  task automatic test_io();
    maddr = 16'hAB99; mdata_in = 8'h42; miorq = 1'b0; mwr = 1'b0; mm1 = 1'b1;
    tick(3);
`ifdef IORQ_BRIDGE_EN
    tests++; if (cs !== 1'b0 || rmirq !== 1'b0) begin fails++; $display("FAIL io_start got=%b/%b exp=0/0", cs, rmirq); end
    tests++; if (md_out !== 16'h0099) begin fails++; $display("FAIL io_addr got=%h exp=0099", md_out); end
    a0 = 1'b1; tick();
    rdone = 1'b1; tick();
    tests++; if (mwait_oe !== 1'b0) begin fails++; $display("FAIL io_done got=%b exp=0", mwait_oe); end
`else
    tick(2);
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL io_ignored got=%b exp=1", cs); end
`endif
    msx_idle(); tick(4);
    maddr = 16'h00A0; miorq = 1'b0; mwr = 1'b0; tick(5);
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL io_nomatch got=%b exp=1", cs); end
    msx_idle(); tick(3);
    maddr = 16'h0098; miorq = 1'b0; mm1 = 1'b0; mrd = 1'b0; tick(5);
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL io_inta got=%b exp=1", cs); end
    msx_idle(); tick(3);
  endtask

  initial begin
    reset = 1'b1; rreset = 1'b0; maddr = '0; mdata_in = '0; md_in = '0;
    msx_idle();
    test_reset();
    test_write();
    test_read();
    test_rdone_vs_timeout();
    test_timeout();
    test_reset_mid();
    test_abort();
    test_io();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end
endmodule
